// File: rtl/word_seq_detector_if.sv
// Symbol, configuration and result signals of the word sequence detector.
// The master drives symbols and pattern writes; the slave is the detector.
interface word_seq_detector_if #(
    parameter int CHAR_W  = 7,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);

    logic              letter_valid;
    logic [CHAR_W-1:0] letter;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [CHAR_W-1:0] cfg_char;
    logic              cfg_opt;
    logic              cfg_len_we;
    logic [LEN_W-1:0]  cfg_len;
    logic              hit;
    logic [LEN_W-1:0]  progress;
    logic [CNT_W-1:0]  hit_count;

    modport master (
        output letter_valid, letter, cfg_we, cfg_addr, cfg_char, cfg_opt,
               cfg_len_we, cfg_len,
        input  hit, progress, hit_count
    );

    modport slave (
        input  letter_valid, letter, cfg_we, cfg_addr, cfg_char, cfg_opt,
               cfg_len_we, cfg_len,
        output hit, progress, hit_count
    );
endinterface

// File: rtl/word_seq_detector.sv
// Programmable word matcher with optional (skippable) pattern slots, non-overlapping hits.
// Define WSD_HIT_COUNT_EN to build the saturating hit counter; otherwise hit_count is tied to 0.
module word_seq_detector #(
    parameter int CHAR_W  = 7,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    word_seq_detector_if.slave bus
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W:0]  MAX_LEN_V = (LEN_W + 1)'(MAX_LEN);
    localparam logic [LEN_W:0]  MIN_LEN_V = (LEN_W + 1)'(2);
    localparam logic [LEN_W:0]  ONE_V     = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0]  TWO_V     = (LEN_W + 1)'(2);
    localparam logic [ADDR_W:0] SLOTS_V   = (ADDR_W + 1)'(MAX_LEN);

    logic [CHAR_W-1:0]  pat [MAX_LEN];
    logic [MAX_LEN-1:0] opt;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   state, state_nxt;
    logic               hit, hit_nxt;

    logic [LEN_W:0]     i_w, len_w, nxt1, nxt2, adv;
    logic [ADDR_W-1:0]  cur_idx, skip_idx;
    logic               len_ok, skip_ok, addr_ok, cfg_any;

    assign i_w      = {1'b0, state};
    assign len_w    = {1'b0, len};
    assign nxt1     = i_w + ONE_V;
    assign nxt2     = i_w + TWO_V;
    assign len_ok   = (len_w >= MIN_LEN_V) && (len_w <= MAX_LEN_V);
    assign cur_idx  = state[ADDR_W-1:0];
    assign skip_idx = (nxt1 < MAX_LEN_V) ? nxt1[ADDR_W-1:0] : '0;
    // An optional slot can only be skipped when a real successor slot exists; slot 0 is never optional.
    assign skip_ok  = (state != '0) && opt[cur_idx] && (nxt1 < len_w);
    assign addr_ok  = ({1'b0, bus.cfg_addr} < SLOTS_V);
    assign cfg_any  = bus.cfg_we || bus.cfg_len_we;

    always_comb begin
        state_nxt = state;
        hit_nxt   = 1'b0;
        adv       = '0;
        if (cfg_any || !len_ok) begin
            state_nxt = '0;
        end else if (bus.letter_valid) begin
            if (bus.letter == pat[cur_idx]) begin
                adv = nxt1;
            end else if (skip_ok && (bus.letter == pat[skip_idx])) begin
                adv = nxt2;
            end else if (bus.letter == pat[0]) begin
                adv = ONE_V;
            end else begin
                adv = '0;
            end
            if (adv == len_w) begin
                state_nxt = '0;
                hit_nxt   = 1'b1;
            end else begin
                state_nxt = adv[LEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
            hit   <= 1'b0;
        end else begin
            state <= state_nxt;
            hit   <= hit_nxt;
        end
    end

    // Pattern store; out-of-range slot writes on non power-of-two MAX_LEN are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                pat[k] <= '0;
            end
            opt <= '0;
            len <= '0;
        end else begin
            if (bus.cfg_we && addr_ok) begin
                pat[bus.cfg_addr] <= bus.cfg_char;
                opt[bus.cfg_addr] <= bus.cfg_opt;
            end
            if (bus.cfg_len_we) begin
                len <= bus.cfg_len;
            end
        end
    end

`ifdef WSD_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (hit_nxt) begin
            hit_cnt <= sat_inc(hit_cnt);
        end
    end

    assign bus.hit_count = hit_cnt;
`else
    assign bus.hit_count = CNT_W'(0);
`endif

    assign bus.hit      = hit;
    assign bus.progress = state;
endmodule

// File: tb/tb_word_seq_detector.sv
// Self-checking bench for word_seq_detector: directed COLOUR scenarios plus randomized
// patterns and streams, compared every cycle against a rule-level reference model.
module tb_word_seq_detector;
    localparam int CHAR_W  = 7;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int ADDR_W  = $clog2(MAX_LEN);
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    word_seq_detector_if #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    word_seq_detector #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int hits_seen = 0;
    bit chk_en    = 1'b0;

    // Reference model state
    int m_pat [MAX_LEN];
    bit m_opt [MAX_LEN];
    int m_len;
    int m_i;
    int e_hit;
    int e_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < MAX_LEN; k++) begin
            m_pat[k] = 0;
            m_opt[k] = 1'b0;
        end
        m_len = 0;
        m_i   = 0;
        e_hit = 0;
        e_cnt = 0;
    endtask

    // Next matched count from the transition rules, evaluated in priority order.
    function automatic int advance(input int i, input int c);
        if (c == m_pat[i]) return i + 1;
        if (i > 0 && m_opt[i] && (i + 1 < m_len) && c == m_pat[i + 1]) return i + 2;
        if (c == m_pat[0]) return 1;
        return 0;
    endfunction

    task automatic model_step();
        bit cfg;
        int nv;
        cfg   = bus.cfg_we || bus.cfg_len_we;
        e_hit = 0;
        if (cfg || m_len < 2 || m_len > MAX_LEN) begin
            m_i = 0;
        end else if (bus.letter_valid) begin
            nv = advance(m_i, int'(bus.letter));
            if (nv == m_len) begin
                m_i   = 0;
                e_hit = 1;
            end else begin
                m_i = nv;
            end
        end
        if (bus.cfg_we) begin
            m_pat[int'(bus.cfg_addr)] = int'(bus.cfg_char);
            m_opt[int'(bus.cfg_addr)] = bus.cfg_opt;
        end
        if (bus.cfg_len_we) m_len = int'(bus.cfg_len);
`ifdef WSD_HIT_COUNT_EN
        if (e_hit == 1 && e_cnt < CNT_MAX) e_cnt++;
`endif
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hit", int'(bus.hit), e_hit);
            chk("progress", int'(bus.progress), m_i);
            chk("hit_count", int'(bus.hit_count), e_cnt);
            if (bus.hit) hits_seen++;
        end
    end

    task automatic clear_inputs();
        bus.letter_valid = 1'b0;
        bus.letter       = '0;
        bus.cfg_we       = 1'b0;
        bus.cfg_addr     = '0;
        bus.cfg_char     = '0;
        bus.cfg_opt      = 1'b0;
        bus.cfg_len_we   = 1'b0;
        bus.cfg_len      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int c);
        bus.letter_valid = 1'b1;
        bus.letter       = CHAR_W'(c);
        tick();
        bus.letter_valid = 1'b0;
    endtask

    task automatic wr_slot(input int a, input int c, input bit o);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = ADDR_W'(a);
        bus.cfg_char = CHAR_W'(c);
        bus.cfg_opt  = o;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic wr_len(input int l);
        bus.cfg_len_we = 1'b1;
        bus.cfg_len    = LEN_W'(l);
        tick();
        bus.cfg_len_we = 1'b0;
    endtask

    task automatic prog_colour();
        string w;
        w = "COLOUR";
        for (int k = 0; k < 6; k++) wr_slot(k, int'(w[k]), k == 4);
        wr_len(6);
    endtask

    task automatic send_str(input string s);
        for (int k = 0; k < s.len(); k++) send(int'(s[k]));
    endtask

    task automatic run_word(input string s, input int exp_hits);
        int h0;
        h0 = hits_seen;
        send_str(s);
        idle(2);
        chk({"hits_", s}, hits_seen - h0, exp_hits);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_hit", int'(bus.hit), 0);
        chk("rst_progress", int'(bus.progress), 0);
        chk("rst_hit_count", int'(bus.hit_count), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_cycle();
        int r;
        r = int'($urandom_range(0, 99));
        bus.letter_valid = ($urandom_range(0, 9) < 7);
        bus.letter       = CHAR_W'(8'h41 + $urandom_range(0, 3));
        if (r < 2) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = ADDR_W'($urandom_range(0, MAX_LEN - 1));
            bus.cfg_char = CHAR_W'(8'h41 + $urandom_range(0, 2));
            bus.cfg_opt  = $urandom_range(0, 1) == 1;
        end else if (r < 3) begin
            bus.cfg_len_we = 1'b1;
            bus.cfg_len    = LEN_W'($urandom_range(2, MAX_LEN));
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        int h0;
        int plen;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        chk("por_hit", int'(bus.hit), 0);
        chk("por_progress", int'(bus.progress), 0);
        chk("por_hit_count", int'(bus.hit_count), 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(2);

        prog_colour();
        // Skip of optional U: hit must be visible right after the edge that took R
        send_str("COLOR");
        #1;
        chk("latency_hit", int'(bus.hit), 1);
        idle(2);
        run_word("COLOUR", 1);
        run_word("CCOLOR", 1);
        send_str("COL");
        chk("progress_COL", int'(bus.progress), 3);
        send(8'h58);
        chk("progress_after_X", int'(bus.progress), 0);
        run_word("OR", 0);
        run_word("COLOROLOR", 1);

        // Configuration write mid-match abandons the partial match
        send_str("COL");
        wr_slot(0, 8'h43, 1'b0);
        chk("progress_after_cfg", int'(bus.progress), 0);
        run_word("OR", 0);

        // Letter presented together with a config write is discarded
        bus.letter_valid = 1'b1;
        bus.letter       = CHAR_W'(8'h43);
        wr_slot(0, 8'h43, 1'b0);
        bus.letter_valid = 1'b0;
        run_word("OLOR", 0);

        // Reset mid-match discards the partial match and disables the matcher
        send_str("COLO");
        do_reset();
        run_word("UR", 0);
        run_word("COLOR", 0);

        prog_colour();
        wr_len(0);
        run_word("COLOR", 0);
        wr_len(9);
        run_word("COLOR", 0);
        wr_len(1);
        run_word("CCC", 0);

        // Counter behaviour over five hits
        do_reset();
        prog_colour();
        h0 = hits_seen;
        repeat (5) run_word("COLOR", 1);
        chk("five_hits", hits_seen - h0, 5);
`ifdef WSD_HIT_COUNT_EN
        chk("hit_count_saturated", int'(bus.hit_count), 3);
`else
        chk("hit_count_absent", int'(bus.hit_count), 0);
`endif

        // Randomized patterns over a small alphabet so matches are frequent
        for (int round = 0; round < 20; round++) begin
            plen = int'($urandom_range(2, MAX_LEN));
            for (int k = 0; k < MAX_LEN; k++)
                wr_slot(k, 8'h41 + int'($urandom_range(0, 2)), $urandom_range(0, 2) == 0);
            if (round % 7 == 6) wr_len(int'($urandom_range(0, 1)) * 9);
            else wr_len(plen);
            for (int c = 0; c < 150; c++) rand_cycle();
            if (round == 10) begin
                send_str("AB");
                do_reset();
            end
        end
        idle(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
